// File: rtl/ovl_pkg.sv
// Shared types and constants for the text overlay sequencer.
package ovl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        FINISH = 2'd2
    } mode_t;

    localparam int ROM_AW = 11;
    localparam int BIT_W  = 3;
    localparam int ROW_W  = 8;

    localparam int REQ_START  = 0;
    localparam int REQ_SCORE  = 1;
    localparam int REQ_FINISH = 2;

    // Base overlay enable pattern for each screen mode (finish bit may be gated by blink).
    function automatic logic [2:0] mode_enables(input mode_t m);
        logic [2:0] en;
        case (m)
            IDLE:    en = 3'b001;
            PLAY:    en = 3'b010;
            FINISH:  en = 3'b100;
            default: en = 3'b000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/ovl_prio_arb.sv
// Combinational fixed-priority arbiter: lowest set request index wins.
module ovl_prio_arb #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_any
);

    // Scan from the top down so the lowest requesting index is the last one written.
    always_comb begin
        o_grant = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/text_overlay_ctrl.sv
// Screen-mode sequencer and shared font-ROM arbiter for the text overlays.
// Optional feature macro: OVL_BLINK_EN (blinks the finish banner in FINISH).
module text_overlay_ctrl
    import ovl_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int ROM_LAT      = 1,
    parameter int HOLD_FRAMES  = 180,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_frame_tick,
    input  logic                    i_start_btn,
    input  logic                    i_finish_evt,
    input  logic [N_REQ-1:0]        i_req_on,
    input  logic [N_REQ*ROM_AW-1:0] i_req_rom_addr,
    input  logic [N_REQ*BIT_W-1:0]  i_req_bit_addr,
    output logic [N_REQ-1:0]        o_ovl_en,
    output logic [ROM_AW-1:0]       o_rom_addr,
    input  logic [ROW_W-1:0]        i_rom_data,
    output logic                    o_text_pix,
    output logic [1:0]              o_mode,
    output logic [15:0]             o_conflict_cnt
);

    localparam int FCNT_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(ROW_W - 1);

    mode_t             r_mode, w_mode_nxt;
    mode_t             r_pend_state, w_pend_state_nxt;
    logic              r_pend_vld, w_pend_vld_nxt;
    logic [FCNT_W-1:0] r_fcnt, w_fcnt_nxt;
    logic              w_apply;
    logic              w_fin_en;
    logic [2:0]        w_base;
    logic [N_REQ-1:0]  w_req_m;
    logic [N_REQ-1:0]  w_grant;
    logic              w_any;
    logic [ROM_AW-1:0] w_rom_addr;
    logic [BIT_W-1:0]  w_bit;
    logic [ROM_LAT-1:0] r_vld_sr;
    logic [BIT_W-1:0]  r_bit_sr [ROM_LAT];
    logic              r_text_pix;
    logic [15:0]       r_conflict_cnt;

    // A latched pending state is only applied on a frame tick, so modes never change mid-frame.
    assign w_apply = i_frame_tick && r_pend_vld;

    // State register for mode, pending request and finish-hold frame counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode       <= IDLE;
            r_pend_state <= IDLE;
            r_pend_vld   <= 1'b0;
            r_fcnt       <= '0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_pend_state <= w_pend_state_nxt;
            r_pend_vld   <= w_pend_vld_nxt;
            r_fcnt       <= w_fcnt_nxt;
        end
    end

    // Next-state logic: apply pending on tick, otherwise latch the one event valid for this mode.
    always_comb begin
        w_mode_nxt       = r_mode;
        w_pend_state_nxt = r_pend_state;
        w_pend_vld_nxt   = r_pend_vld;
        w_fcnt_nxt       = r_fcnt;
        if (w_apply) begin
            w_mode_nxt       = r_pend_state;
            w_pend_state_nxt = IDLE;
            w_pend_vld_nxt   = 1'b0;
            w_fcnt_nxt       = '0;
        end else begin
            case (r_mode)
                IDLE: begin
                    if (i_start_btn && !r_pend_vld) begin
                        w_pend_state_nxt = PLAY;
                        w_pend_vld_nxt   = 1'b1;
                    end
                end
                PLAY: begin
                    if (i_finish_evt && !r_pend_vld) begin
                        w_pend_state_nxt = FINISH;
                        w_pend_vld_nxt   = 1'b1;
                    end
                end
                FINISH: begin
                    if (i_frame_tick) begin
                        if (r_fcnt == FCNT_W'(HOLD_FRAMES - 1)) begin
                            w_pend_state_nxt = IDLE;
                            w_pend_vld_nxt   = 1'b1;
                        end else begin
                            w_fcnt_nxt = r_fcnt + FCNT_W'(1);
                        end
                    end
                end
                default: w_mode_nxt = IDLE;
            endcase
        end
    end

`ifdef OVL_BLINK_EN
    localparam int BCNT_W = $clog2(BLINK_FRAMES + 1);
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_blink_on;

    // Blink phase counter: restarts visible on every mode change, toggles every BLINK_FRAMES ticks.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bcnt     <= '0;
            r_blink_on <= 1'b1;
        end else if (w_apply) begin
            r_bcnt     <= '0;
            r_blink_on <= 1'b1;
        end else if (r_mode == FINISH && i_frame_tick) begin
            if (r_bcnt == BCNT_W'(BLINK_FRAMES - 1)) begin
                r_bcnt     <= '0;
                r_blink_on <= ~r_blink_on;
            end else begin
                r_bcnt <= r_bcnt + BCNT_W'(1);
            end
        end
    end

    assign w_fin_en = r_blink_on;
`else
    assign w_fin_en = 1'b1;
`endif

    // Enables decode directly from the mode register so they switch with o_mode.
    always_comb begin
        w_base             = mode_enables(r_mode);
        w_base[REQ_FINISH] = w_base[REQ_FINISH] & w_fin_en;
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_en
        if (g < 3) begin : g_used
            assign o_ovl_en[g] = w_base[g];
        end else begin : g_unused
            assign o_ovl_en[g] = 1'b0;
        end
    end

    assign w_req_m = i_req_on & o_ovl_en;

    ovl_prio_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .i_req   (w_req_m),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // One-hot AND-OR mux of the winner's ROM address and bit select; zero with no winner.
    always_comb begin
        w_rom_addr = '0;
        w_bit      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_rom_addr = w_rom_addr | i_req_rom_addr[ROM_AW*i +: ROM_AW];
                w_bit      = w_bit | i_req_bit_addr[BIT_W*i +: BIT_W];
            end
        end
    end

    assign o_rom_addr = w_rom_addr;

    // Delay valid and bit select by the ROM latency, then pick the pixel (bit 7 is leftmost).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vld_sr   <= '0;
            for (int i = 0; i < ROM_LAT; i++) r_bit_sr[i] <= '0;
            r_text_pix <= 1'b0;
        end else begin
            for (int i = ROM_LAT - 1; i > 0; i--) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
                r_bit_sr[i] <= r_bit_sr[i-1];
            end
            r_vld_sr[0] <= w_any;
            r_bit_sr[0] <= w_bit;
            r_text_pix  <= r_vld_sr[ROM_LAT-1] && i_rom_data[MSB_IDX - r_bit_sr[ROM_LAT-1]];
        end
    end

    // Saturating count of cycles where several overlays ask for the ROM, enabled or not.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_conflict_cnt <= '0;
        end else if ($countones(i_req_on) > 1 && r_conflict_cnt != 16'hFFFF) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign o_text_pix     = r_text_pix;
    assign o_mode         = r_mode;
    assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Self-checking bench for text_overlay_ctrl: directed tables/sequences plus
// randomized traffic compared against a behavioural model of the overlay rules.
module tb_text_overlay_ctrl;

    localparam int N_REQ        = 3;
    localparam int ROM_LAT      = 1;
    localparam int HOLD_FRAMES  = 180;
    localparam int BLINK_FRAMES = 30;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_frame_tick = 1'b0;
    logic        i_start_btn = 1'b0;
    logic        i_finish_evt = 1'b0;
    logic [2:0]  i_req_on = '0;
    logic [32:0] i_req_rom_addr = '0;
    logic [8:0]  i_req_bit_addr = '0;
    logic [2:0]  o_ovl_en;
    logic [10:0] o_rom_addr;
    logic [7:0]  i_rom_data;
    logic        o_text_pix;
    logic [1:0]  o_mode;
    logic [15:0] o_conflict_cnt;

    text_overlay_ctrl #(
        .N_REQ        (N_REQ),
        .ROM_LAT      (ROM_LAT),
        .HOLD_FRAMES  (HOLD_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_frame_tick   (i_frame_tick),
        .i_start_btn    (i_start_btn),
        .i_finish_evt   (i_finish_evt),
        .i_req_on       (i_req_on),
        .i_req_rom_addr (i_req_rom_addr),
        .i_req_bit_addr (i_req_bit_addr),
        .o_ovl_en       (o_ovl_en),
        .o_rom_addr     (o_rom_addr),
        .i_rom_data     (i_rom_data),
        .o_text_pix     (o_text_pix),
        .o_mode         (o_mode),
        .o_conflict_cnt (o_conflict_cnt)
    );

    always #5 clk = ~clk;

    // Font ROM model with ROM_LAT cycles of read latency.
    logic [7:0] rom_mem [2048];
    logic [7:0] rom_q [ROM_LAT];
    always @(posedge clk) begin
        rom_q[0] <= rom_mem[o_rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rom_q[i] <= rom_q[i-1];
    end
    assign i_rom_data = rom_q[ROM_LAT-1];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Stimulus held across steps.
    logic        g_rst = 1'b1;
    logic [2:0]  g_req = '0;
    logic [32:0] g_addr = '0;
    logic [8:0]  g_bit = '0;

    // Behavioural model: mode, pending target (-1 = none), ticks spent in FINISH.
    bit  m_init = 0;
    int  m_mode = 0;
    int  m_pend = -1;
    int  m_ticks = 0;
    int  m_cc = 0;
    bit  m_pix_exp = 0;
    bit  pixq[$];

    function automatic logic [2:0] m_en();
        case (m_mode)
            0: return 3'b001;
            1: return 3'b010;
            2: begin
`ifdef OVL_BLINK_EN
                return (((m_ticks / BLINK_FRAMES) % 2) == 0) ? 3'b100 : 3'b000;
`else
                return 3'b100;
`endif
            end
            default: return 3'b000;
        endcase
    endfunction

    function automatic int m_winner();
        logic [2:0] en;
        en = m_en();
        for (int i = 0; i < N_REQ; i++) if (g_req[i] && en[i]) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic ft, input logic sb, input logic fe, input int w);
        logic [10:0] a;
        logic [2:0]  b;
        logic [7:0]  row;
        bit          pix;
        if (g_rst) begin
            m_init = 1; m_mode = 0; m_pend = -1; m_ticks = 0; m_cc = 0; m_pix_exp = 0;
            pixq.delete();
            for (int i = 0; i < ROM_LAT; i++) pixq.push_back(1'b0);
            return;
        end
        pix = 0;
        if (w >= 0) begin
            a = g_addr[w*11 +: 11];
            b = g_bit[w*3 +: 3];
            row = rom_mem[a];
            pix = row[7 - b];
        end
        pixq.push_back(pix);
        m_pix_exp = pixq.pop_front();
        if ($countones(g_req) > 1 && m_cc < 65535) m_cc++;
        if (ft && m_pend >= 0) begin
            m_mode = m_pend; m_pend = -1; m_ticks = 0;
        end else begin
            if (m_mode == 0 && sb && m_pend < 0) m_pend = 1;
            if (m_mode == 1 && fe && m_pend < 0) m_pend = 2;
            if (m_mode == 2 && ft) begin
                m_ticks++;
                if (m_ticks == HOLD_FRAMES) m_pend = 0;
            end
        end
    endtask

    // One clock: drive, check combinational address, clock, check registered outputs.
    task automatic step(input logic ft, input logic sb, input logic fe);
        int w;
        logic [10:0] ea;
        i_reset = g_rst; i_frame_tick = ft; i_start_btn = sb; i_finish_evt = fe;
        i_req_on = g_req; i_req_rom_addr = g_addr; i_req_bit_addr = g_bit;
        #1;
        w = m_winner();
        ea = (w < 0) ? 11'h0 : g_addr[w*11 +: 11];
        if (m_init) chk("rom_addr", 32'(o_rom_addr), 32'(ea));
        model_edge(ft, sb, fe, w);
        @(posedge clk);
        #1;
        if (m_init) begin
            chk("mode", 32'(o_mode), 32'(m_mode));
            chk("ovl_en", 32'(o_ovl_en), 32'(m_en()));
            chk("text_pix", 32'(o_text_pix), 32'(m_pix_exp));
            chk("conflict_cnt", 32'(o_conflict_cnt), 32'(m_cc));
        end
        @(negedge clk);
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [10:0] exp_addr;
        logic        exp_conf;
    } vec_t;

    vec_t tbl [6];
    int   c0;
    logic exp_blink;

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
        rom_mem[11'h46A] = 8'h80;

        // Arbitration table in IDLE (only the start overlay is enabled).
        tbl[0] = '{3'b001, 11'h111, 1'b0};
        tbl[1] = '{3'b010, 11'h000, 1'b0};
        tbl[2] = '{3'b110, 11'h000, 1'b1};
        tbl[3] = '{3'b111, 11'h111, 1'b1};
        tbl[4] = '{3'b101, 11'h111, 1'b1};
        tbl[5] = '{3'b000, 11'h000, 1'b0};

        g_rst = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        g_rst = 1'b0;
        step(0, 0, 0);
        chk("reset_mode", 32'(o_mode), 32'd0);
        chk("reset_ovl_en", 32'(o_ovl_en), 32'b001);
        chk("reset_text_pix", 32'(o_text_pix), 32'd0);
        chk("reset_conflict", 32'(o_conflict_cnt), 32'd0);

        g_addr = {11'h333, 11'h222, 11'h111};
        g_bit  = 9'b0;
        for (int i = 0; i < 6; i++) begin
            g_req = tbl[i].req;
            c0 = m_cc;
            step(0, 0, 0);
            chk("tbl_addr", 32'(o_rom_addr), 32'(tbl[i].exp_addr));
            chk("tbl_conflict", 32'(o_conflict_cnt), 32'(c0 + int'(tbl[i].exp_conf)));
        end
        g_req = '0;

        // Start mid-frame: no change until the next tick.
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("start_wait_mode", 32'(o_mode), 32'd0);
        step(1, 0, 0);
        chk("start_mode", 32'(o_mode), 32'd1);
        chk("start_ovl_en", 32'(o_ovl_en), 32'b010);

        // All requesters active in PLAY: score wins, pixel appears two registers later.
        g_req  = 3'b111;
        g_addr = {11'h200, 11'h46A, 11'h100};
        g_bit  = 9'b0;
        c0 = m_cc;
        step(0, 0, 0);
        chk("addr_46A", 32'(o_rom_addr), 32'h46A);
        chk("cc_inc1", 32'(o_conflict_cnt), 32'(c0 + 1));
        step(0, 0, 0);
        chk("pix_46A", 32'(o_text_pix), 32'd1);
        chk("cc_inc2", 32'(o_conflict_cnt), 32'(c0 + 2));

        // Reset mid-frame flushes the pixel pipeline.
        g_rst = 1'b1;
        step(0, 0, 0);
        chk("rst_mid_pix", 32'(o_text_pix), 32'd0);
        chk("rst_mid_mode", 32'(o_mode), 32'd0);
        g_rst = 1'b0;
        step(0, 0, 0);
        chk("rst_flush_pix", 32'(o_text_pix), 32'd0);
        g_req = '0;

        // Start and tick in the same cycle: applies on the second tick only.
        step(1, 1, 0);
        step(0, 0, 0);
        chk("same_cycle_first", 32'(o_mode), 32'd0);
        tick();
        chk("same_cycle_second", 32'(o_mode), 32'd1);

        // Enter FINISH, hold for HOLD_FRAMES ticks, finish_evt ignored meanwhile.
        step(0, 0, 1);
        tick();
        chk("finish_mode", 32'(o_mode), 32'd2);
        chk("finish_en2", 32'(o_ovl_en[2]), 32'd1);
        for (int k = 1; k <= HOLD_FRAMES; k++) begin
            if (k % 7 == 0) step(0, 0, 1);
            tick();
            if (k == 30 || k == 60) begin
`ifdef OVL_BLINK_EN
                exp_blink = (k == 60);
`else
                exp_blink = 1'b1;
`endif
                chk("blink_en2", 32'(o_ovl_en[2]), 32'(exp_blink));
            end
        end
        chk("hold_still_finish", 32'(o_mode), 32'd2);
        tick();
        chk("hold_back_idle", 32'(o_mode), 32'd0);
        chk("hold_idle_en", 32'(o_ovl_en), 32'b001);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            g_req  = 3'($urandom);
            g_addr = {11'($urandom), 11'($urandom), 11'($urandom)};
            g_bit  = 9'($urandom);
            g_rst  = ($urandom_range(0, 599) == 0);
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        end
        g_rst = 1'b0;
        step(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
